// File: rtl/instr_mem_loader.sv
// instr_mem_loader: run-time loadable instruction memory with a registered 1-cycle fetch port.
// Optional macro INSTR_PARITY_EN adds a stored even-parity bit per word, rechecked on every fetch.
module instr_mem_loader #(
   parameter int DEPTH = 512,
   parameter int IW = 32,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          LOAD_START,
   input  logic [IW-1:0] LOAD_DATA,
   input  logic          LOAD_VALID,
   input  logic          LOAD_LAST,
   output logic          LOAD_READY,
   input  logic          FETCH_EN,
   input  logic [AW-1:0] PC_AXI,
   output logic [IW-1:0] INSTR_AXI,
   output logic          INSTR_VALID,
   output logic          PC_ERR,
   output logic [AW:0]   LOADED_CNT,
   output logic          BUSY
);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
   typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_t;
   state_t        r_state;
   logic [AW:0]   r_cnt;
   logic [IW-1:0] r_mem [DEPTH];
   logic          w_ready;
   logic          w_hs;
   logic          w_in_range;
   logic          w_word_ok;
`ifdef INSTR_PARITY_EN
   logic          r_par [DEPTH];
   // store even parity alongside each accepted word; no reset so contents survive RST
   always_ff @(posedge CLK) begin
      if (w_hs) r_par[r_cnt[AW-1:0]] <= ^LOAD_DATA;
   end
   assign w_word_ok = w_in_range && ((^r_mem[PC_AXI]) == r_par[PC_AXI]);
`else
   assign w_word_ok = w_in_range;
`endif
   assign w_ready = (r_state == S_LOAD) && (r_cnt < DEPTH_CNT) && !LOAD_START;
   assign w_hs = LOAD_VALID && w_ready;
   assign w_in_range = {1'b0, PC_AXI} < r_cnt;
   assign LOAD_READY = w_ready;
   assign LOADED_CNT = r_cnt;
   // memory write port; array is deliberately not reset, LOADED_CNT=0 hides stale words
   always_ff @(posedge CLK) begin
      if (w_hs) r_mem[r_cnt[AW-1:0]] <= LOAD_DATA;
   end
   // load FSM and registered fetch; the fetch uses the pre-edge state so a fetch racing LOAD_START still reads old contents
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_EMPTY;
         r_cnt       <= '0;
         INSTR_AXI   <= '0;
         INSTR_VALID <= 1'b0;
         PC_ERR      <= 1'b0;
         BUSY        <= 1'b0;
      end else begin
         if (r_state == S_RUN && FETCH_EN) begin
            INSTR_VALID <= 1'b1;
            INSTR_AXI   <= w_word_ok ? r_mem[PC_AXI] : '0;
            PC_ERR      <= !w_word_ok;
         end else begin
            INSTR_VALID <= 1'b0;
            PC_ERR      <= 1'b0;
         end
         if (LOAD_START) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            BUSY    <= 1'b1;
         end else if (w_hs) begin
            r_cnt <= r_cnt + 1'b1;
            if (LOAD_LAST || r_cnt == LAST_IDX) begin
               r_state <= S_RUN;
               BUSY    <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed bench for instr_mem_loader built with DEPTH=8.
module tb_instr_mem_loader;
   localparam int DEPTH = 8;
   localparam int IW = 32;
   localparam int AW = 3;
   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          LOAD_START = 1'b0;
   logic [IW-1:0] LOAD_DATA = '0;
   logic          LOAD_VALID = 1'b0;
   logic          LOAD_LAST = 1'b0;
   logic          LOAD_READY;
   logic          FETCH_EN = 1'b0;
   logic [AW-1:0] PC_AXI = '0;
   logic [IW-1:0] INSTR_AXI;
   logic          INSTR_VALID;
   logic          PC_ERR;
   logic [AW:0]   LOADED_CNT;
   logic          BUSY;
   int            n_vec = 0;
   int            n_err = 0;

   instr_mem_loader #(.DEPTH(DEPTH), .IW(IW)) dut (
      .CLK(CLK), .RST(RST), .LOAD_START(LOAD_START), .LOAD_DATA(LOAD_DATA),
      .LOAD_VALID(LOAD_VALID), .LOAD_LAST(LOAD_LAST), .LOAD_READY(LOAD_READY),
      .FETCH_EN(FETCH_EN), .PC_AXI(PC_AXI), .INSTR_AXI(INSTR_AXI),
      .INSTR_VALID(INSTR_VALID), .PC_ERR(PC_ERR), .LOADED_CNT(LOADED_CNT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [IW-1:0] prog [3];
      prog[0] = 32'h00051402;
      prog[1] = 32'h000C3802;
      prog[2] = 32'h0005578B;
      tick();
      tick();
      chk("rst_valid", INSTR_VALID, 0);
      chk("rst_err", PC_ERR, 0);
      chk("rst_cnt", LOADED_CNT, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_instr", INSTR_AXI, 0);
      RST = 1'b0;
      FETCH_EN = 1'b1;
      PC_AXI = 3'd0;
      tick();
      chk("empty_fetch_valid", INSTR_VALID, 0);
      chk("empty_fetch_err", PC_ERR, 0);
      chk("empty_cnt", LOADED_CNT, 0);
      FETCH_EN = 1'b0;
      LOAD_START = 1'b1;
      tick();
      LOAD_START = 1'b0;
      chk("start_busy", BUSY, 1);
      chk("start_cnt", LOADED_CNT, 0);
      for (int i = 0; i < 3; i++) begin
         LOAD_VALID = 1'b1;
         LOAD_DATA = prog[i];
         LOAD_LAST = (i == 2);
         #1;
         chk("load3_ready", LOAD_READY, 1);
         tick();
      end
      LOAD_VALID = 1'b0;
      LOAD_LAST = 1'b0;
      #1;
      chk("load3_cnt", LOADED_CNT, 3);
      chk("load3_busy", BUSY, 0);
      chk("run_ready", LOAD_READY, 0);
      FETCH_EN = 1'b1;
      PC_AXI = 3'd1;
      tick();
      chk("pc1_instr", INSTR_AXI, 32'h000C3802);
      chk("pc1_valid", INSTR_VALID, 1);
      chk("pc1_err", PC_ERR, 0);
      PC_AXI = 3'd5;
      tick();
      chk("pc5_instr", INSTR_AXI, 0);
      chk("pc5_valid", INSTR_VALID, 1);
      chk("pc5_err", PC_ERR, 1);
      PC_AXI = 3'd2;
      tick();
      chk("pc2_instr", INSTR_AXI, 32'h0005578B);
      chk("pc2_err", PC_ERR, 0);
      PC_AXI = 3'd3;
      tick();
      chk("pc3_instr", INSTR_AXI, 0);
      chk("pc3_err", PC_ERR, 1);
      PC_AXI = 3'd0;
      tick();
      chk("pc0_instr", INSTR_AXI, 32'h00051402);
      FETCH_EN = 1'b0;
      tick();
      chk("idle_valid", INSTR_VALID, 0);
      chk("idle_err", PC_ERR, 0);
      chk("idle_hold", INSTR_AXI, 32'h00051402);
      LOAD_START = 1'b1;
      tick();
      LOAD_START = 1'b0;
      LOAD_LAST = 1'b1;
      tick();
      chk("last_novalid_busy", BUSY, 1);
      chk("last_novalid_cnt", LOADED_CNT, 0);
      LOAD_LAST = 1'b0;
      for (int i = 0; i < 9; i++) begin
         LOAD_VALID = 1'b1;
         LOAD_DATA = 32'hA0000000 + i;
         #1;
         chk("full_ready", LOAD_READY, (i < 8) ? 1 : 0);
         tick();
      end
      LOAD_VALID = 1'b0;
      chk("full_cnt", LOADED_CNT, 8);
      chk("full_busy", BUSY, 0);
      FETCH_EN = 1'b1;
      PC_AXI = 3'd7;
      tick();
      chk("full_pc7", INSTR_AXI, 32'hA0000007);
      chk("full_pc7_err", PC_ERR, 0);
      PC_AXI = 3'd3;
      LOAD_START = 1'b1;
      tick();
      chk("race_instr", INSTR_AXI, 32'hA0000003);
      chk("race_valid", INSTR_VALID, 1);
      chk("race_busy", BUSY, 1);
      chk("race_cnt", LOADED_CNT, 0);
      FETCH_EN = 1'b0;
      tick();
      chk("zero_len_busy", BUSY, 1);
      chk("zero_len_cnt", LOADED_CNT, 0);
      LOAD_START = 1'b0;
      for (int i = 0; i < 2; i++) begin
         LOAD_VALID = 1'b1;
         LOAD_DATA = 32'hB0000000 + i;
         tick();
      end
      LOAD_VALID = 1'b0;
      chk("mid_cnt", LOADED_CNT, 2);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("midrst_cnt", LOADED_CNT, 0);
      chk("midrst_busy", BUSY, 0);
      FETCH_EN = 1'b1;
      PC_AXI = 3'd0;
      tick();
      chk("midrst_fetch_valid", INSTR_VALID, 0);
      FETCH_EN = 1'b0;
      LOAD_START = 1'b1;
      LOAD_VALID = 1'b1;
      LOAD_DATA = 32'h12345678;
      #1;
      chk("start_valid_ready", LOAD_READY, 0);
      tick();
      LOAD_START = 1'b0;
      LOAD_VALID = 1'b0;
      chk("start_valid_cnt", LOADED_CNT, 0);
      chk("start_valid_busy", BUSY, 1);
`ifdef INSTR_PARITY_EN
      LOAD_VALID = 1'b1;
      LOAD_LAST = 1'b1;
      LOAD_DATA = 32'hDEADBEEF;
      tick();
      LOAD_VALID = 1'b0;
      LOAD_LAST = 1'b0;
      dut.r_par[0] = ~dut.r_par[0];
      FETCH_EN = 1'b1;
      PC_AXI = 3'd0;
      tick();
      FETCH_EN = 1'b0;
      chk("par_instr", INSTR_AXI, 0);
      chk("par_valid", INSTR_VALID, 1);
      chk("par_err", PC_ERR, 1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
